// File: rtl/wb_stream_writer.sv
// Drains a valid/ready byte stream into single Wishbone classic write cycles, with bounded retry.
// Optional REQ timeout abort is enabled by defining WB_STREAM_WRITER_TIMEOUT_EN.
module wb_stream_writer #(
    parameter int DAT_WIDTH   = 8,
    parameter int MAX_RETRIES = 3,
    parameter int TIMEOUT     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_valid_i,
    input  logic [DAT_WIDTH-1:0] s_data_i,
    output logic                 s_ready_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    output logic                 done_o,
    output logic                 fail_o,
    output logic [1:0]           fail_code_o,
    output logic [15:0]          done_count_o
);

    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        BACKOFF
    } state_t;

    state_t               state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic [DAT_WIDTH-1:0] dat_q, dat_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;
    logic [1:0]           fail_code_q, fail_code_d;
    logic [15:0]          done_count_q, done_count_d;

`ifdef WB_STREAM_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT);
    logic [TW-1:0]        timer_q, timer_d;
`endif

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        dat_d        = dat_q;
        retry_d      = retry_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        fail_code_d  = fail_code_q;
        done_count_d = done_count_q;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
        timer_d      = timer_q;
`endif
        case (state_q)
            IDLE: begin
                if (s_valid_i) begin
                    dat_d   = s_data_i;
                    retry_d = '0;
                    state_d = REQ;
                    cyc_d   = 1'b1;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            REQ: begin
                // err beats rty beats ack when the device raises several at once
                if (err_i) begin
                    state_d     = IDLE;
                    cyc_d       = 1'b0;
                    fail_d      = 1'b1;
                    fail_code_d = 2'b01;
                end else if (rty_i) begin
                    cyc_d = 1'b0;
                    if (retry_q == RW'(MAX_RETRIES)) begin
                        state_d     = IDLE;
                        fail_d      = 1'b1;
                        fail_code_d = 2'b10;
                    end else begin
                        state_d = BACKOFF;
                        retry_d = retry_q + 1'b1;
                    end
                end else if (ack_i) begin
                    state_d      = IDLE;
                    cyc_d        = 1'b0;
                    done_d       = 1'b1;
                    done_count_d = done_count_q + 16'd1;
                end
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    cyc_d       = 1'b0;
                    fail_d      = 1'b1;
                    fail_code_d = 2'b11;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            BACKOFF: begin
                state_d = REQ;
                cyc_d   = 1'b1;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
                timer_d = '0;
`endif
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cyc_q        <= 1'b0;
            dat_q        <= '0;
            retry_q      <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            fail_code_q  <= 2'b00;
            done_count_q <= 16'd0;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
            timer_q      <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            dat_q        <= dat_d;
            retry_q      <= retry_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            fail_code_q  <= fail_code_d;
            done_count_q <= done_count_d;
`ifdef WB_STREAM_WRITER_TIMEOUT_EN
            timer_q      <= timer_d;
`endif
        end
    end

    // stb and we share the cycle flop: this block only ever issues single writes
    assign s_ready_o    = (state_q == IDLE) && !rst_i;
    assign cyc_o        = cyc_q;
    assign stb_o        = cyc_q;
    assign we_o         = cyc_q;
    assign dat_o        = dat_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign fail_code_o  = fail_code_q;
    assign done_count_o = done_count_q;

endmodule
